// File: rtl/monopix_pkg.sv
// Shared definitions for the MONOPIX serial readout transmitter.
// Readout FSM states, hit-word field layout and a hit-word packing helper.
package monopix_pkg;

    localparam int unsigned WORD_WIDTH_DEF = 27;

    // Hit word layout, MSB first on the wire: COL | ROW | LE | TE
    localparam int unsigned TE_LSB  = 0;
    localparam int unsigned TE_W    = 6;
    localparam int unsigned LE_LSB  = 6;
    localparam int unsigned LE_W    = 6;
    localparam int unsigned ROW_LSB = 12;
    localparam int unsigned ROW_W   = 9;
    localparam int unsigned COL_LSB = 21;
    localparam int unsigned COL_W   = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    function automatic logic [WORD_WIDTH_DEF-1:0] make_hit(
        input logic [COL_W-1:0] col,
        input logic [ROW_W-1:0] row,
        input logic [LE_W-1:0]  le,
        input logic [TE_W-1:0]  te
    );
        return {col, row, le, te};
    endfunction

endpackage

// File: rtl/monopix_tx_fifo.sv
// Synchronous hit FIFO, DEPTH x WORD_WIDTH, with a registered full flag.
// A read and a write may happen in the same cycle, including while full.
module monopix_tx_fifo #(
    parameter int unsigned WORD_WIDTH = 27,
    parameter int unsigned DEPTH      = 16,
    localparam int unsigned AW        = $clog2(DEPTH),
    localparam int unsigned CW        = AW + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [WORD_WIDTH-1:0] wdata_i,
    input  logic                  we_i,
    input  logic                  re_i,
    output logic [WORD_WIDTH-1:0] rdata_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [CW-1:0]         count_o
);

    logic [WORD_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wptr_q, rptr_q;
    logic [CW-1:0]         count_q, count_d;
    logic                  full_q;
    logic                  wr_ok, rd_ok;

    // A pop in the same cycle frees the slot the write needs
    assign rd_ok = re_i & (count_q != '0);
    assign wr_ok = we_i & (~full_q | rd_ok);

    always_comb begin
        count_d = count_q;
        if (wr_ok && !rd_ok) begin
            count_d = count_q + CW'(1);
        end else if (!wr_ok && rd_ok) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            if (wr_ok) wptr_q <= wptr_q + AW'(1);
            if (rd_ok) rptr_q <= rptr_q + AW'(1);
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_ok) mem[wptr_q] <= wdata_i;
    end

    assign rdata_o = mem[rptr_q];
    assign full_o  = full_q;
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/monopix_readout_tx.sv
// Chip-side MONOPIX serial readout: hit FIFO plus FREEZE/READ handshake answered
// with TOKEN, MSB-first DATA and a gated CLK_OUT (receiver samples on CLK_OUT rise).
module monopix_readout_tx
    import monopix_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = WORD_WIDTH_DEF,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  EN,
    input  logic [WORD_WIDTH-1:0] HIT_DATA,
    input  logic                  HIT_WE,
    output logic                  HIT_FULL,
    input  logic                  FREEZE,
    input  logic                  READ,
    output logic                  TOKEN,
    output logic                  DATA,
    output logic                  CLK_OUT,
    output logic                  BUSY,
    output logic [CNT_WIDTH-1:0]  LOST_CNT,
    output logic [CNT_WIDTH-1:0]  ERR_CNT
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned BW = $clog2(WORD_WIDTH);

    logic [WORD_WIDTH-1:0] fifo_rdata;
    logic                  fifo_full, fifo_empty, pop;
    logic [CW-1:0]         fifo_count;

    monopix_tx_fifo #(
        .WORD_WIDTH (WORD_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_i   (RST),
        .wdata_i (HIT_DATA),
        .we_i    (HIT_WE),
        .re_i    (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    logic                  freeze_q, freeze_qq, read_q, read_qq;
    logic                  freeze_rise, freeze_fall, read_rise, start_ok;
    logic [CW-1:0]         frozen_q, frozen_d;
    state_t                state_q, state_d;
    logic [WORD_WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic                  data_q, data_d, clk_out_q, clk_out_d, token_q;
    logic [CNT_WIDTH-1:0]  lost_q, lost_d, err_q, err_d;

    assign freeze_rise = freeze_q & ~freeze_qq;
    assign freeze_fall = ~freeze_q & freeze_qq;
    assign read_rise   = read_q & ~read_qq;
    assign start_ok    = EN & freeze_q & (frozen_q != '0) & ~fifo_empty;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_d     = bit_q;
        data_d    = data_q;
        clk_out_d = clk_out_q;
        pop       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (read_rise && start_ok) state_d = LOAD;
            end
            LOAD: begin
                pop       = 1'b1;
                shift_d   = fifo_rdata;
                data_d    = fifo_rdata[WORD_WIDTH-1];
                clk_out_d = 1'b0;
                bit_d     = '0;
                state_d   = SHIFT;
            end
            SHIFT: begin
                if (!clk_out_q) begin
                    clk_out_d = 1'b1;
                end else begin
                    // Falling CLK_OUT: present the next bit, or end the word
                    clk_out_d = 1'b0;
                    shift_d   = shift_q << 1;
                    if (bit_q == BW'(WORD_WIDTH - 1)) begin
                        data_d  = 1'b0;
                        bit_d   = '0;
                        state_d = IDLE;
                    end else begin
                        data_d = shift_q[WORD_WIDTH-2];
                        bit_d  = bit_q + BW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        frozen_d = frozen_q;
        if (freeze_fall) begin
            frozen_d = '0;
        end else if (freeze_rise) begin
            frozen_d = fifo_count - CW'(pop);
        end else if (pop && frozen_q != '0) begin
            frozen_d = frozen_q - CW'(1);
        end
    end

    always_comb begin
        lost_d = lost_q;
        err_d  = err_q;
        if (HIT_WE && fifo_full && !pop && lost_q != '1) lost_d = lost_q + CNT_WIDTH'(1);
        // A READ rise is an error unless it starts a word from IDLE
        if (read_rise && EN && ((state_q != IDLE) || !start_ok) && err_q != '1) begin
            err_d = err_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            freeze_q  <= 1'b0;
            freeze_qq <= 1'b0;
            read_q    <= 1'b0;
            read_qq   <= 1'b0;
            frozen_q  <= '0;
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_q     <= '0;
            data_q    <= 1'b0;
            clk_out_q <= 1'b0;
            token_q   <= 1'b0;
            lost_q    <= '0;
            err_q     <= '0;
        end else begin
            freeze_q  <= FREEZE;
            freeze_qq <= freeze_q;
            read_q    <= READ;
            read_qq   <= read_q;
            frozen_q  <= frozen_d;
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_q     <= bit_d;
            data_q    <= data_d;
            clk_out_q <= clk_out_d;
            token_q   <= EN & freeze_q & (frozen_q != '0);
            lost_q    <= lost_d;
            err_q     <= err_d;
        end
    end

    assign HIT_FULL = fifo_full;
    assign TOKEN    = token_q;
    assign DATA     = data_q;
    assign CLK_OUT  = clk_out_q;
    assign BUSY     = (state_q != IDLE);
    assign LOST_CNT = lost_q;
    assign ERR_CNT  = err_q;

endmodule

// File: tb/tb_monopix_readout_tx.sv
// Directed/randomized bench for monopix_readout_tx with a queue-based reference model
// and a serial receiver that rebuilds words on CLK_OUT rising edges.
module tb_monopix_readout_tx;
    import monopix_pkg::*;

    localparam int unsigned W  = 27;
    localparam int unsigned D  = 16;
    localparam int unsigned CN = 8;

    logic          CLK = 1'b0;
    logic          RST, EN, HIT_WE, FREEZE, READ;
    logic [W-1:0]  HIT_DATA;
    logic          HIT_FULL, TOKEN, DATA, CLK_OUT, BUSY;
    logic [CN-1:0] LOST_CNT, ERR_CNT;

    monopix_readout_tx #(
        .WORD_WIDTH (W),
        .DEPTH      (D),
        .CNT_WIDTH  (CN)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .EN       (EN),
        .HIT_DATA (HIT_DATA),
        .HIT_WE   (HIT_WE),
        .HIT_FULL (HIT_FULL),
        .FREEZE   (FREEZE),
        .READ     (READ),
        .TOKEN    (TOKEN),
        .DATA     (DATA),
        .CLK_OUT  (CLK_OUT),
        .BUSY     (BUSY),
        .LOST_CNT (LOST_CNT),
        .ERR_CNT  (ERR_CNT)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model
    logic [W-1:0] model_q[$];
    int model_lost = 0;
    int model_err  = 0;

    // Serial receiver
    logic [W-1:0] rx_q[$];
    logic [W-1:0] rx_word = '0;
    int           rx_cnt = 0;
    logic         prev_clk_out = 1'b0;

    always @(negedge CLK) begin
        if (RST) begin
            rx_cnt       = 0;
            prev_clk_out = 1'b0;
        end else begin
            if (CLK_OUT && !prev_clk_out) begin
                rx_word = {rx_word[W-2:0], DATA};
                rx_cnt++;
                if (rx_cnt == W) begin
                    rx_q.push_back(rx_word);
                    rx_cnt = 0;
                end
            end
            prev_clk_out = CLK_OUT;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [W-1:0] rand_word();
        return make_hit(6'($urandom_range(0, 63)), 9'($urandom_range(0, 511)),
                        6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
    endfunction

    task automatic do_reset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        model_q.delete();
        rx_q.delete();
        model_lost = 0;
        model_err  = 0;
        tick();
    endtask

    task automatic write_hits(input int n);
        for (int i = 0; i < n; i++) begin
            HIT_DATA = rand_word();
            HIT_WE   = 1'b1;
            if (model_q.size() < D) model_q.push_back(HIT_DATA);
            else if (model_lost < 255) model_lost++;
            tick();
        end
        HIT_WE = 1'b0;
    endtask

    task automatic set_freeze(input logic v);
        FREEZE = v;
        repeat (3) tick();
    endtask

    task automatic wait_word(input string tag, input logic [W-1:0] exp);
        int n;
        logic [W-1:0] got;
        n = 0;
        while (rx_q.size() == 0 && n < 3 * W) begin
            tick();
            n++;
        end
        check({tag, " rx_avail"}, 64'(rx_q.size() > 0), 64'd1);
        if (rx_q.size() > 0) begin
            got = rx_q.pop_front();
            check({tag, " word"}, 64'(got), 64'(exp));
        end
        repeat (3) tick();
        check({tag, " idle"}, 64'(BUSY), 64'd0);
    endtask

    // READ pulse; checks MSB at t+3 and first CLK_OUT rise at t+4
    task automatic read_word(input string tag, input bit mid_read);
        logic [W-1:0] exp;
        exp = model_q.pop_front();
        READ = 1'b1;
        tick();
        READ = 1'b0;
        tick();
        tick();
        check({tag, " msb_t3"}, 64'(DATA), 64'(exp[W-1]));
        check({tag, " clk_lo_t3"}, 64'(CLK_OUT), 64'd0);
        tick();
        check({tag, " clk_hi_t4"}, 64'(CLK_OUT), 64'd1);
        if (mid_read) begin
            repeat (8) tick();
            READ = 1'b1;
            tick();
            READ = 1'b0;
            model_err++;
        end
        wait_word(tag, exp);
    endtask

    task automatic stray_read(input string tag);
        bit active;
        active = 1'b0;
        READ = 1'b1;
        tick();
        READ = 1'b0;
        repeat (10) begin
            tick();
            if (CLK_OUT || BUSY) active = 1'b1;
        end
        check({tag, " no_activity"}, 64'(active), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] exp, nw;
        RST = 1'b0; EN = 1'b1; HIT_WE = 1'b0; FREEZE = 1'b0; READ = 1'b0; HIT_DATA = '0;
        do_reset();
        check("rst TOKEN", 64'(TOKEN), 64'd0);
        check("rst DATA", 64'(DATA), 64'd0);
        check("rst CLK_OUT", 64'(CLK_OUT), 64'd0);
        check("rst BUSY", 64'(BUSY), 64'd0);
        check("rst HIT_FULL", 64'(HIT_FULL), 64'd0);
        check("rst LOST_CNT", 64'(LOST_CNT), 64'd0);
        check("rst ERR_CNT", 64'(ERR_CNT), 64'd0);

        // 1: three words read MSB first
        write_hits(3);
        set_freeze(1'b1);
        check("t1 token", 64'(TOKEN), 64'd1);
        for (int i = 0; i < 3; i++) begin
            read_word("t1", 1'b0);
            repeat (3) tick();
            check("t1 token_after_pop", 64'(TOKEN), 64'(i < 2));
        end
        check("t1 err", 64'(ERR_CNT), 64'(model_err));

        // 2: overflow, simultaneous pop+write, saturation, drain
        FREEZE = 1'b0;
        do_reset();
        write_hits(20);
        check("t2 full", 64'(HIT_FULL), 64'd1);
        check("t2 lost", 64'(LOST_CNT), 64'(model_lost));
        set_freeze(1'b1);
        exp = model_q.pop_front();
        READ = 1'b1;
        tick();
        READ = 1'b0;
        tick();
        nw = rand_word();
        HIT_DATA = nw;
        HIT_WE = 1'b1;
        model_q.push_back(nw);
        tick();
        HIT_WE = 1'b0;
        check("t2 full_after_popwrite", 64'(HIT_FULL), 64'd1);
        check("t2 lost_after_popwrite", 64'(LOST_CNT), 64'd4);
        wait_word("t2 popwrite", exp);
        write_hits(260);
        check("t2 lost_sat", 64'(LOST_CNT), 64'(model_lost));
        set_freeze(1'b0);
        set_freeze(1'b1);
        for (int i = 0; i < D; i++) read_word("t2 drain", 1'b0);
        repeat (2) tick();
        check("t2 token_drained", 64'(TOKEN), 64'd0);
        check("t2 not_full", 64'(HIT_FULL), 64'd0);

        // 3: hits during freeze are not readable until refreeze
        FREEZE = 1'b0;
        do_reset();
        write_hits(2);
        set_freeze(1'b1);
        write_hits(5);
        read_word("t3a", 1'b0);
        read_word("t3b", 1'b0);
        check("t3 token_after_2", 64'(TOKEN), 64'd0);
        set_freeze(1'b0);
        set_freeze(1'b1);
        check("t3 token_refreeze", 64'(TOKEN), 64'd1);
        for (int i = 0; i < 5; i++) begin
            read_word("t3c", 1'b0);
            tick();
            check("t3 token_count", 64'(TOKEN), 64'(i < 4));
        end

        // 4: protocol errors
        FREEZE = 1'b0;
        do_reset();
        write_hits(1);
        stray_read("t4 unfrozen");
        model_err++;
        check("t4 err1", 64'(ERR_CNT), 64'(model_err));
        set_freeze(1'b1);
        read_word("t4 midread", 1'b1);
        check("t4 err2", 64'(ERR_CNT), 64'(model_err));

        // 5: reset mid-shift
        FREEZE = 1'b0;
        do_reset();
        write_hits(18);
        stray_read("t5 pre");
        set_freeze(1'b1);
        READ = 1'b1;
        tick();
        READ = 1'b0;
        repeat (12) tick();
        RST = 1'b1;
        tick();
        check("t5 DATA", 64'(DATA), 64'd0);
        check("t5 CLK_OUT", 64'(CLK_OUT), 64'd0);
        check("t5 TOKEN", 64'(TOKEN), 64'd0);
        check("t5 BUSY", 64'(BUSY), 64'd0);
        check("t5 HIT_FULL", 64'(HIT_FULL), 64'd0);
        check("t5 LOST_CNT", 64'(LOST_CNT), 64'd0);
        check("t5 ERR_CNT", 64'(ERR_CNT), 64'd0);
        RST = 1'b0;
        model_q.delete();
        rx_q.delete();
        model_lost = 0;
        model_err  = 0;
        repeat (4) tick();
        check("t5 token_empty", 64'(TOKEN), 64'd0);
        stray_read("t5 empty");
        model_err++;
        check("t5 err_empty", 64'(ERR_CNT), 64'(model_err));

        // 6: EN gating
        FREEZE = 1'b0;
        do_reset();
        write_hits(3);
        set_freeze(1'b1);
        EN = 1'b0;
        repeat (2) tick();
        check("t6 token_dis", 64'(TOKEN), 64'd0);
        stray_read("t6 dis");
        check("t6 err_dis", 64'(ERR_CNT), 64'(model_err));
        EN = 1'b1;
        repeat (2) tick();
        check("t6 token_en", 64'(TOKEN), 64'd1);
        for (int i = 0; i < 3; i++) read_word("t6", 1'b0);
        check("t6 err_end", 64'(ERR_CNT), 64'(model_err));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
